// File: rtl/lynxTypes.sv
// Shared types for the user request path.
// Holds the request descriptor carried by the submission queues, the upper bound
// on request sources and the arbiter FSM state encoding.
package lynxTypes;

  localparam int unsigned N_REQ_SRC_MAX = 16;

  // Request descriptor; the arbiter forwards it untouched.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [5:0]  strm;
    logic [3:0]  dest;
    logic [47:0] vaddr;
    logic [27:0] len;
    logic        last;
  } req_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2,
    StWait  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   elig  - per-source eligibility
//   ptr   - index with highest priority this cycle
//   grant - one-hot grant (all zero when nothing is eligible)
//   idx   - binary index of the granted source
//   any   - at least one source is eligible
module rr_pick #(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned SRC_BITS = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]    elig,
  input  logic [SRC_BITS-1:0] ptr,
  output logic [N_SRC-1:0]    grant,
  output logic [SRC_BITS-1:0] idx,
  output logic                any
);

  logic [SRC_BITS-1:0] pos;

  // Scan from the farthest offset back to ptr so the closest eligible source wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    any   = |elig;
    for (int unsigned k = N_SRC; k > 0; k--) begin
      pos = SRC_BITS'((32'(ptr) + k - 1) % N_SRC);
      if (elig[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/user_req_arb.sv
// Round-robin merge of N_SRC request streams into one, with per-source credit
// limits released by completions and a flush/drain handshake.
// Ports:
//   aclk, areset        - clock, synchronous active-high reset
//   s_valid/s_ready/s_data - per-source request streams
//   m_valid/m_ready/m_data/m_src - merged registered output and its source
//   cpl_valid/cpl_src   - one completion per cycle, returns a credit
//   src_en              - per-source enable
//   flush/flush_done    - drain request (level) and completion pulse
//   cpl_err             - sticky: completion with no outstanding request
module user_req_arb
  import lynxTypes::*;
#(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned N_OUTSTANDING = 8,
  parameter int unsigned SRC_BITS      = $clog2(N_SRC)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [N_SRC-1:0]    s_valid,
  output logic [N_SRC-1:0]    s_ready,
  input  req_t [N_SRC-1:0]    s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output req_t                m_data,
  output logic [SRC_BITS-1:0] m_src,
  input  logic                cpl_valid,
  input  logic [SRC_BITS-1:0] cpl_src,
  input  logic [N_SRC-1:0]    src_en,
  input  logic                flush,
  output logic                flush_done,
  output logic                cpl_err
);

  localparam int unsigned CNT_W = $clog2(N_OUTSTANDING + 1);

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [N_SRC];
  logic [SRC_BITS-1:0] rr_ptr_q;
  logic                m_valid_q;
  req_t                m_data_q;
  logic [SRC_BITS-1:0] m_src_q;
  logic                flush_done_q;
  logic                cpl_err_q;

  logic [N_SRC-1:0]    elig, grant, cpl_hit, cnt_nz;
  logic [SRC_BITS-1:0] grant_idx, rr_ptr_next;
  logic                grant_any, issue_en, accept, cpl_bad, all_idle;

  always_comb begin
    elig    = '0;
    cpl_hit = '0;
    cnt_nz  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cnt_nz[i]  = cnt_q[i] != '0;
      elig[i]    = s_valid[i] && src_en[i] && (cnt_q[i] < CNT_W'(N_OUTSTANDING));
      cpl_hit[i] = cpl_valid && (cpl_src == SRC_BITS'(i));
    end
  end

  rr_pick #(
    .N_SRC    (N_SRC),
    .SRC_BITS (SRC_BITS)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Out-of-range cpl_src matches no source, so it lands in cpl_bad as well.
  assign cpl_bad     = cpl_valid && !(|(cpl_hit & cnt_nz));
  assign all_idle    = !m_valid_q && (cnt_nz == '0);
  assign issue_en    = (state_q == StRun) && !areset && (!m_valid_q || m_ready);
  assign s_ready     = issue_en ? grant : '0;
  assign accept      = issue_en && grant_any;
  assign rr_ptr_next = (grant_idx == SRC_BITS'(N_SRC - 1)) ? '0 : grant_idx + SRC_BITS'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush) state_d = StDrain;
      StDrain: if (all_idle) state_d = StDone;
      StDone:  state_d = flush ? StWait : StRun;
      StWait:  if (!flush) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StRun;
      rr_ptr_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_src_q      <= '0;
      flush_done_q <= 1'b0;
      cpl_err_q    <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_d == StDone);
      if (cpl_bad) cpl_err_q <= 1'b1;
      if (accept) begin
        rr_ptr_q  <= rr_ptr_next;
        m_valid_q <= 1'b1;
        m_data_q  <= s_data[grant_idx];
        m_src_q   <= grant_idx;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
      // Accept and completion on the same source cancel out.
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (s_ready[i] && !(cpl_hit[i] && cnt_nz[i])) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (!s_ready[i] && cpl_hit[i] && cnt_nz[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_src      = m_src_q;
  assign flush_done = flush_done_q;
  assign cpl_err    = cpl_err_q;

endmodule

// File: doc/user_req_arb.md
# user_req_arb

Round-robin arbiter that merges `N_SRC` independent user submission-queue request streams (`req_t`) into one request stream. It feeds the user request mux's read or write sink, one instance per direction. It enforces a per-source outstanding-request credit limit, released by completions. It also provides a flush sequence that stops issue and waits for all sources to drain.

## Interface
Parameters:
- `N_SRC`, 4: number of requesting sources, 2..16.
- `N_OUTSTANDING`, 8: maximum in-flight requests per source, 1..255.
- `SRC_BITS`, `$clog2(N_SRC)`: source index width.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `s_valid`  in  N_SRC  per-source request valid.
- `s_ready`  out  N_SRC  per-source request ready.
- `s_data`  in  N_SRC x $bits(req_t)  per-source request.
- `m_valid`  out  1  merged request valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  $bits(req_t)  merged request, passed unmodified.
- `m_src`  out  SRC_BITS  source index of `m_data`.
- `cpl_valid`  in  1  one completion this cycle.
- `cpl_src`  in  SRC_BITS  source the completion belongs to.
- `src_en`  in  N_SRC  per-source enable; a disabled source is never granted.
- `flush`  in  1  level request to drain.
- `flush_done`  out  1  one-cycle pulse when the drain completes.
- `cpl_err`  out  1  sticky flag: completion received for a source with zero outstanding requests.

## Operation
- Counters `cnt[i]`, width `$clog2(N_OUTSTANDING+1)`:
  - reset 0;
  - +1 when source i is accepted (`s_valid[i] && s_ready[i]`);
  - −1 on `cpl_valid && cpl_src==i && cnt[i]!=0`.
- Simultaneous accept and completion on the same source: net unchanged.
- Completion when `cnt[i]==0`: ignored and sets `cpl_err` (cleared only by reset).
- `cpl_src >= N_SRC`: ignored and sets `cpl_err`.
- Eligible(i) = `s_valid[i] && src_en[i] && cnt[i] < N_OUTSTANDING`.
- Grant: first eligible index scanning `rr_ptr, rr_ptr+1, … ` modulo N_SRC.
  - `rr_ptr` resets to 0.
  - On every accept, `rr_ptr` becomes (granted index + 1) mod N_SRC.
  - With no accept, `rr_ptr` holds.
- Output register is a single stage, `free = !m_valid || m_ready`.
- `s_ready[i] = (state==RUN) && free && grant[i]`. At most one `s_ready` bit is high.
- On accept, `m_data` and `m_src` load and `m_valid` is set. `m_valid` clears on `m_ready` with no new accept.
- `m_valid`, `m_data`, `m_src` hold stable while `m_valid && !m_ready`.

FSM states:
- RUN (reset): normal issue. `flush` high → DRAIN.
- DRAIN: no grants. When `!m_valid` and every `cnt[i]==0` → DONE. This can occur on the first DRAIN cycle.
- DONE: `flush_done=1` for exactly this cycle → RUN if `flush` is low, else stays in WAIT.
- WAIT: no grants; `flush` low → RUN.

Reset values: `s_ready=0`, `m_valid=0`, `m_data=0`, `m_src=0`, `flush_done=0`, `cpl_err=0`. Reset mid-drain returns to RUN with all counters 0; in-flight completions arriving afterwards set `cpl_err`.

## Timing
- Latency: source accept at cycle t → `m_valid` at t+1.
- Throughput: one request per cycle while `m_ready` is held high.
- `s_ready` is combinational from `s_valid`, `src_en`, counters, state and `m_ready`.
- No combinational path from `s_valid` to `m_valid`.
- `cpl_valid` affects eligibility from the next cycle.
- `flush` asserted in cycle t blocks grants from t+1. A request accepted in cycle t is still counted and drained.
- `flush_done` is registered.

## Structure
- The `req_t` typedef stays in `lynxTypes`.
- Add to `lynxTypes`:
  - `N_REQ_SRC_MAX=16`;
  - arbiter FSM enum `arb_state_t` (RUN, DRAIN, DONE, WAIT).
- Sub-module `rr_pick`: combinational round-robin picker (eligible vector, pointer → one-hot grant plus index), parameterised by `N_SRC`.
- Counters, FSM and output register live in `user_req_arb`.

## Test plan
- Round-robin fairness: N_SRC=4, all sources valid continuously, `m_ready=1`, completions returned immediately.
  - Required: `m_src` sequence 0,1,2,3,0,1,… with no gaps after the first output cycle.
- Credit limit: N_OUTSTANDING=2, only source 1 valid, no completions.
  - Required: exactly 2 accepts, then `s_ready[1]=0`.
  - One `cpl_valid`, `cpl_src=1` → exactly one more accept, on the following cycle.
- Backpressure: `m_ready=0` for 5 cycles with source 2 valid.
  - Required: one accept only; `m_data` and `m_src=2` stay stable all 5 cycles.
  - Releasing `m_ready` → next request is issued back-to-back.
- Simultaneous events: source 0 at `cnt=1` gets an accept and a completion in the same cycle.
  - Required: `cnt` stays 1.
  - A completion for source 3 at `cnt=0` → `cpl_err=1`, sticky until reset.
- Flush: 3 requests outstanding on source 0, `flush` asserted.
  - Required: no `s_ready` afterwards; `flush_done` pulses one cycle after the third completion.
  - With `flush` still high, the FSM stays in WAIT; on deassertion, issue resumes.
- Reset mid-operation: assert `areset` during DRAIN with `m_valid=1`.
  - Required: next cycle `m_valid=0`, counters 0, state RUN, `rr_ptr=0`.
